wb_writer: RTL and testbench

- Write-back side of the register file: produces both register-file write ports (ALU port and memory port) from two sources.
- Sources: execute-stage ALU results, and in-order load responses from the data memory.
- Tracks outstanding loads in an in-order tag FIFO with a per-register busy scoreboard, so issue logic can stall on load-use and WAW hazards.
- Guarantees the two write ports are never active in the same cycle, so no memory write is lost to the ALU-port priority.

---
 rtl/wb_writer.sv | 116 +++++++++++
 tb/tb_wb_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// wb_writer: register-file write-back from ALU results and in-order load responses
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     execute-stage result, always accepted
//   load_issue_valid/rd/ready     load issue handshake (tag FIFO push, busy set)
//   mem_resp_valid/data/ready     in-order load data (data FIFO push)
//   rs1, rs2 -> rs1_busy, rs2_busy scoreboard lookups for decode stalls
//   write_en/addr/data            register-file ALU write port
//   mem_write_en/addr/data        register-file memory write port
//   pending                       outstanding load count
//   err                           sticky protocol-error flag
module wb_writer #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [REG_AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     load_issue_valid,
    input  logic [REG_AW-1:0]        load_issue_rd,
    output logic                     load_issue_ready,
    input  logic                     mem_resp_valid,
    input  logic [XLEN-1:0]          mem_resp_data,
    output logic                     mem_resp_ready,
    input  logic [REG_AW-1:0]        rs1,
    input  logic [REG_AW-1:0]        rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     write_en,
    output logic [REG_AW-1:0]        write_addr,
    output logic [XLEN-1:0]          write_data,
    output logic                     mem_write_en,
    output logic [REG_AW-1:0]        mem_write_addr,
    output logic [XLEN-1:0]          mem_write_data,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NREG = 2 ** REG_AW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [REG_AW-1:0] tag_q [DEPTH];
    logic [XLEN-1:0]   dat_q [DEPTH];
    logic [AW-1:0]     t_wp, t_rp, d_wp, d_rp;
    logic [CW-1:0]     t_cnt, d_cnt;
    logic [NREG-1:0]   busy;
    logic              issue, resp, push, retire, alu_hazard;
    logic [REG_AW-1:0] head_tag;

    assign load_issue_ready = (t_cnt != FULL) && !busy[load_issue_rd];
    assign mem_resp_ready   = d_cnt != FULL;
    assign issue            = load_issue_valid && load_issue_ready;
    assign resp             = mem_resp_valid && mem_resp_ready;
    // a response with no matching outstanding tag is dropped and flagged
    assign push             = resp && (d_cnt != t_cnt);
    // ALU owns the write-back slot; buffered load data drains in idle ALU cycles
    assign retire           = !alu_valid && (d_cnt != '0);
    assign head_tag         = tag_q[t_rp];
    assign alu_hazard       = alu_valid && (alu_rd != '0) && busy[alu_rd];
    assign rs1_busy         = (rs1 != '0) && busy[rs1];
    assign rs2_busy         = (rs2 != '0) && busy[rs2];
    assign pending          = t_cnt;

    always_ff @(posedge clk) begin
        if (issue) tag_q[t_wp] <= load_issue_rd;
        if (push) dat_q[d_wp] <= mem_resp_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_wp           <= '0;
            t_rp           <= '0;
            d_wp           <= '0;
            d_rp           <= '0;
            t_cnt          <= '0;
            d_cnt          <= '0;
            busy           <= '0;
            err            <= 1'b0;
            write_en       <= 1'b0;
            write_addr     <= '0;
            write_data     <= '0;
            mem_write_en   <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            t_wp  <= t_wp + AW'(issue);
            t_rp  <= t_rp + AW'(retire);
            d_wp  <= d_wp + AW'(push);
            d_rp  <= d_rp + AW'(retire);
            t_cnt <= t_cnt + CW'(issue) - CW'(retire);
            d_cnt <= d_cnt + CW'(push) - CW'(retire);
            err   <= err | alu_hazard | (resp && !push);
            // issue to a busy rd is refused, so set and clear never hit the same bit
            if (retire) busy[head_tag] <= 1'b0;
            if (issue && load_issue_rd != '0) busy[load_issue_rd] <= 1'b1;
            if (alu_valid) begin
                write_en     <= 1'b1;
                write_addr   <= alu_rd;
                write_data   <= alu_data;
                mem_write_en <= 1'b0;
            end else if (retire) begin
                write_en       <= 1'b0;
                mem_write_en   <= head_tag != '0;
                mem_write_addr <= head_tag;
                mem_write_data <= dat_q[d_rp];
            end else begin
                write_en     <= 1'b0;
                mem_write_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed self-checking bench for wb_writer
module tb_wb_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        load_issue_valid = 1'b0;
    logic [4:0]  load_issue_rd = '0;
    logic        load_issue_ready;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        mem_resp_ready;
    logic [4:0]  rs1 = '0, rs2 = '0;
    logic        rs1_busy, rs2_busy;
    logic        write_en, mem_write_en, err;
    logic [4:0]  write_addr, mem_write_addr;
    logic [31:0] write_data, mem_write_data;
    logic [2:0]  pending;
    int tests = 0;
    int fails = 0;

    wb_writer dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_issue_valid(load_issue_valid), .load_issue_rd(load_issue_rd),
        .load_issue_ready(load_issue_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_ready(mem_resp_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) step;
        tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL rst_we got %0h exp 0", write_en); end
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL rst_mwe got %0h exp 0", mem_write_en); end
        tests++; if (write_addr !== 5'd0 || write_data !== 32'd0) begin fails++; $display("FAIL rst_wport got %0h/%0h exp 0/0", write_addr, write_data); end
        tests++; if (mem_write_addr !== 5'd0 || mem_write_data !== 32'd0) begin fails++; $display("FAIL rst_mport got %0h/%0h exp 0/0", mem_write_addr, mem_write_data); end
        tests++; if (pending !== 3'd0 || err !== 1'b0) begin fails++; $display("FAIL rst_pend_err got %0d/%0h exp 0/0", pending, err); end
        tests++; if (load_issue_ready !== 1'b1 || mem_resp_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0h/%0h exp 1/1", load_issue_ready, mem_resp_ready); end
        rst = 1'b1;
        step;
    endtask

    task automatic test_alu;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step;
        alu_valid = 1'b0;
        tests++; if (write_en !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL alu_write got %0h/%0d/%h exp 1/5/deadbeef", write_en, write_addr, write_data); end
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL alu_mwe got %0h exp 0", mem_write_en); end
        step;
        tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL alu_we_drop got %0h exp 0", write_en); end
    endtask

    task automatic test_load;
        load_issue_valid = 1'b1; load_issue_rd = 5'd7;
        #1;
        tests++; if (load_issue_ready !== 1'b1) begin fails++; $display("FAIL load_ready got %0h exp 1", load_issue_ready); end
        step;
        load_issue_valid = 1'b0; rs1 = 5'd7;
        #1;
        tests++; if (rs1_busy !== 1'b1 || pending !== 3'd1) begin fails++; $display("FAIL load_busy got %0h/%0d exp 1/1", rs1_busy, pending); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1234;
        step;
        mem_resp_valid = 1'b0;
        tests++; if (mem_write_en !== 1'b0 || rs1_busy !== 1'b1) begin fails++; $display("FAIL load_buffered got %0h/%0h exp 0/1", mem_write_en, rs1_busy); end
        step;
        tests++; if (mem_write_en !== 1'b1 || mem_write_addr !== 5'd7 || mem_write_data !== 32'h1234) begin fails++; $display("FAIL load_retire got %0h/%0d/%h exp 1/7/1234", mem_write_en, mem_write_addr, mem_write_data); end
        tests++; if (rs1_busy !== 1'b0 || pending !== 3'd0 || write_en !== 1'b0) begin fails++; $display("FAIL load_clear got %0h/%0d/%0h exp 0/0/0", rs1_busy, pending, write_en); end
        step;
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL load_mwe_drop got %0h exp 0", mem_write_en); end
    endtask

    task automatic test_alu_priority;
        load_issue_valid = 1'b1; load_issue_rd = 5'd3; rs2 = 5'd3;
        step;
        load_issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h33;
        step;
        mem_resp_valid = 1'b0; alu_rd = 5'd2; alu_data = 32'h22;
        tests++; if (write_en !== 1'b1 || write_addr !== 5'd1 || write_data !== 32'h11 || mem_write_en !== 1'b0) begin fails++; $display("FAIL prio_w1 got %0h/%0d/%h/%0h exp 1/1/11/0", write_en, write_addr, write_data, mem_write_en); end
        step;
        alu_rd = 5'd4; alu_data = 32'h44;
        tests++; if (write_en !== 1'b1 || write_addr !== 5'd2 || mem_write_en !== 1'b0 || rs2_busy !== 1'b1) begin fails++; $display("FAIL prio_w2 got %0h/%0d/%0h/%0h exp 1/2/0/1", write_en, write_addr, mem_write_en, rs2_busy); end
        step;
        alu_valid = 1'b0;
        tests++; if (write_en !== 1'b1 || write_addr !== 5'd4 || write_data !== 32'h44 || mem_write_en !== 1'b0 || rs2_busy !== 1'b1) begin fails++; $display("FAIL prio_w3 got %0h/%0d/%h/%0h/%0h exp 1/4/44/0/1", write_en, write_addr, write_data, mem_write_en, rs2_busy); end
        step;
        tests++; if (write_en !== 1'b0 || mem_write_en !== 1'b1 || mem_write_addr !== 5'd3 || mem_write_data !== 32'h33) begin fails++; $display("FAIL prio_retire got %0h/%0h/%0d/%h exp 0/1/3/33", write_en, mem_write_en, mem_write_addr, mem_write_data); end
        tests++; if (write_addr !== 5'd4 || rs2_busy !== 1'b0 || pending !== 3'd0 || err !== 1'b0) begin fails++; $display("FAIL prio_state got %0d/%0h/%0d/%0h exp 4/0/0/0", write_addr, rs2_busy, pending, err); end
    endtask

    task automatic test_full;
        logic [31:0] rv [4];
        rv[0] = 32'hA; rv[1] = 32'hB; rv[2] = 32'hC; rv[3] = 32'hD;
        for (int i = 0; i < 4; i++) begin
            load_issue_valid = 1'b1; load_issue_rd = 5'(8 + i);
            #1;
            tests++; if (load_issue_ready !== 1'b1) begin fails++; $display("FAIL full_ready%0d got %0h exp 1", i, load_issue_ready); end
            step;
        end
        load_issue_valid = 1'b0; load_issue_rd = 5'd12;
        #1;
        tests++; if (load_issue_ready !== 1'b0 || pending !== 3'd4) begin fails++; $display("FAIL full_block got %0h/%0d exp 0/4", load_issue_ready, pending); end
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = rv[i];
            step;
            tests++; if (load_issue_ready !== (i > 0)) begin fails++; $display("FAIL full_ready_ret%0d got %0h exp %0h", i, load_issue_ready, i > 0); end
            if (i > 0) begin
                tests++; if (mem_write_en !== 1'b1 || mem_write_addr !== 5'(7 + i) || mem_write_data !== rv[i-1]) begin fails++; $display("FAIL full_ret%0d got %0h/%0d/%h exp 1/%0d/%h", i, mem_write_en, mem_write_addr, mem_write_data, 7 + i, rv[i-1]); end
            end else begin
                tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL full_ret0 got %0h exp 0", mem_write_en); end
            end
        end
        mem_resp_valid = 1'b0;
        step;
        tests++; if (mem_write_en !== 1'b1 || mem_write_addr !== 5'd11 || mem_write_data !== 32'hD || pending !== 3'd0) begin fails++; $display("FAIL full_last got %0h/%0d/%h/%0d exp 1/11/d/0", mem_write_en, mem_write_addr, mem_write_data, pending); end
    endtask

    task automatic test_back_to_back;
        load_issue_valid = 1'b1; load_issue_rd = 5'd6; rs1 = 5'd6;
        step;
        tests++; if (load_issue_ready !== 1'b0) begin fails++; $display("FAIL waw_block got %0h exp 0", load_issue_ready); end
        step;
        tests++; if (pending !== 3'd1) begin fails++; $display("FAIL waw_refused got %0d exp 1", pending); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h66;
        step;
        mem_resp_valid = 1'b0;
        tests++; if (load_issue_ready !== 1'b0 || mem_write_en !== 1'b0) begin fails++; $display("FAIL waw_pre got %0h/%0h exp 0/0", load_issue_ready, mem_write_en); end
        step;
        tests++; if (mem_write_en !== 1'b1 || mem_write_addr !== 5'd6 || mem_write_data !== 32'h66 || pending !== 3'd0 || load_issue_ready !== 1'b1) begin fails++; $display("FAIL waw_retire got %0h/%0d/%h/%0d/%0h exp 1/6/66/0/1", mem_write_en, mem_write_addr, mem_write_data, pending, load_issue_ready); end
        step;
        load_issue_valid = 1'b0;
        tests++; if (pending !== 3'd1 || rs1_busy !== 1'b1) begin fails++; $display("FAIL waw_second got %0d/%0h exp 1/1", pending, rs1_busy); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h67;
        step;
        mem_resp_valid = 1'b0;
        step;
        tests++; if (mem_write_en !== 1'b1 || mem_write_data !== 32'h67 || pending !== 3'd0) begin fails++; $display("FAIL waw_drain got %0h/%h/%0d exp 1/67/0", mem_write_en, mem_write_data, pending); end
    endtask

    task automatic test_rd0_and_orphan;
        load_issue_valid = 1'b1; load_issue_rd = 5'd0; rs1 = 5'd0;
        step;
        load_issue_valid = 1'b0;
        tests++; if (rs1_busy !== 1'b0 || pending !== 3'd1 || load_issue_ready !== 1'b1) begin fails++; $display("FAIL rd0_busy got %0h/%0d/%0h exp 0/1/1", rs1_busy, pending, load_issue_ready); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
        step;
        mem_resp_valid = 1'b0;
        step;
        tests++; if (mem_write_en !== 1'b0 || write_en !== 1'b0 || pending !== 3'd0 || err !== 1'b0) begin fails++; $display("FAIL rd0_retire got %0h/%0h/%0d/%0h exp 0/0/0/0", mem_write_en, write_en, pending, err); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD;
        step;
        mem_resp_valid = 1'b0;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL orphan_err got %0h exp 1", err); end
        step;
        tests++; if (mem_write_en !== 1'b0 || pending !== 3'd0 || err !== 1'b1) begin fails++; $display("FAIL orphan_drop got %0h/%0d/%0h exp 0/0/1", mem_write_en, pending, err); end
    endtask

    task automatic test_reset_mid;
        load_issue_valid = 1'b1; load_issue_rd = 5'd13;
        step;
        load_issue_rd = 5'd14;
        step;
        load_issue_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h13;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h55;
        step;
        mem_resp_valid = 1'b0; alu_valid = 1'b0; rs1 = 5'd13; load_issue_rd = 5'd13;
        tests++; if (write_en !== 1'b1 || pending !== 3'd2) begin fails++; $display("FAIL mid_setup got %0h/%0d exp 1/2", write_en, pending); end
        #3 rst = 1'b0;
        #1;
        tests++; if (write_en !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin fails++; $display("FAIL mid_wport got %0h/%0d/%h exp 0/0/0", write_en, write_addr, write_data); end
        tests++; if (mem_write_en !== 1'b0 || mem_write_addr !== 5'd0 || mem_write_data !== 32'd0) begin fails++; $display("FAIL mid_mport got %0h/%0d/%h exp 0/0/0", mem_write_en, mem_write_addr, mem_write_data); end
        tests++; if (pending !== 3'd0 || err !== 1'b0 || rs1_busy !== 1'b0) begin fails++; $display("FAIL mid_state got %0d/%0h/%0h exp 0/0/0", pending, err, rs1_busy); end
        #2 rst = 1'b1;
        step;
        tests++; if (load_issue_ready !== 1'b1 || mem_write_en !== 1'b0 || pending !== 3'd0) begin fails++; $display("FAIL mid_release got %0h/%0h/%0d exp 1/0/0", load_issue_ready, mem_write_en, pending); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h14;
        step;
        mem_resp_valid = 1'b0;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL mid_late_resp got %0h exp 1", err); end
    endtask

    task automatic test_alu_hazard;
        rst = 1'b0;
        step;
        rst = 1'b1;
        step;
        load_issue_valid = 1'b1; load_issue_rd = 5'd9;
        step;
        load_issue_valid = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL haz_pre got %0h exp 0", err); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h77;
        step;
        alu_valid = 1'b0;
        tests++; if (err !== 1'b1 || write_en !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h77) begin fails++; $display("FAIL haz_err got %0h/%0h/%0d/%h exp 1/1/9/77", err, write_en, write_addr, write_data); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_alu_priority;
        test_full;
        test_back_to_back;
        test_rd0_and_orphan;
        test_reset_mid;
        test_alu_hazard;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
